// File: rtl/mc_pad_gpio_ctrl.sv
// Per-pin pad control for a bank of bidirectional pads: registered output path,
// synchronized and debounced input path, and sticky rise/fall edge interrupts.
module mc_pad_gpio_ctrl #(
  parameter int unsigned NumPads        = 8,
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumPads-1:0] out_i,
  input  logic [NumPads-1:0] oe_i,
  input  logic [NumPads-1:0] debounce_en_i,
  input  logic [NumPads-1:0] irq_rise_en_i,
  input  logic [NumPads-1:0] irq_fall_en_i,
  input  logic [NumPads-1:0] irq_clear_i,
  output logic [NumPads-1:0] pad_d_o,
  output logic [NumPads-1:0] pad_oe_o,
  input  logic [NumPads-1:0] pad_d_i,
  output logic [NumPads-1:0] in_o,
  output logic [NumPads-1:0] irq_pending_o,
  output logic               irq_o
);

  localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [NumPads-1:0] pad_d_q, pad_oe_q;
  logic [NumPads-1:0] sync_q [SyncStages];
  logic [NumPads-1:0] sync_s;
  logic [CntW-1:0]    cnt_q [NumPads];
  logic [CntW-1:0]    cnt_d [NumPads];
  logic [NumPads-1:0] stable_q, stable_d;
  logic [NumPads-1:0] stable_prev_q;
  logic [NumPads-1:0] rise_evt, fall_evt, set_evt;
  logic [NumPads-1:0] pending_q, pending_d;

  // Output path: straight registered copy of the register-file values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_d_q  <= '0;
      pad_oe_q <= '0;
    end else begin
      pad_d_q  <= out_i;
      pad_oe_q <= oe_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(SyncStages); s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad_d_i;
      for (int s = 1; s < int'(SyncStages); s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_s = sync_q[SyncStages-1];

  // A new level is accepted only after DebounceCycles consecutive mismatching
  // cycles; any matching cycle or a disabled cycle throws the partial count away.
  always_comb begin
    stable_d = stable_q;
    for (int p = 0; p < int'(NumPads); p++) begin
      cnt_d[p] = '0;
      if (!debounce_en_i[p]) begin
        stable_d[p] = sync_s[p];
      end else if (sync_s[p] != stable_q[p]) begin
        if (cnt_q[p] == CntMax) begin
          stable_d[p] = sync_s[p];
        end else begin
          cnt_d[p] = cnt_q[p] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int p = 0; p < int'(NumPads); p++) cnt_q[p] <= '0;
    end else begin
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int p = 0; p < int'(NumPads); p++) cnt_q[p] <= cnt_d[p];
    end
  end

  // Edges are taken from the registered filtered level, so pending rises the
  // cycle after in_o changes; a new event beats a simultaneous clear.
  assign rise_evt  = stable_q & ~stable_prev_q;
  assign fall_evt  = ~stable_q & stable_prev_q;
  assign set_evt   = (rise_evt & irq_rise_en_i) | (fall_evt & irq_fall_en_i);
  assign pending_d = set_evt | (pending_q & ~irq_clear_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pad_d_o       = pad_d_q;
  assign pad_oe_o      = pad_oe_q;
  assign in_o          = stable_q;
  assign irq_pending_o = pending_q;
  assign irq_o         = |pending_q;

endmodule

// File: tb/tb_mc_pad_gpio_ctrl.sv
// Directed bench for mc_pad_gpio_ctrl: output-path vector table plus hand-written
// sequences for sync latency, debounce, IRQ set/clear priority and reset re-acquisition.
module tb_mc_pad_gpio_ctrl;

  localparam int NP = 8;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [NP-1:0] out_i, oe_i, debounce_en_i, irq_rise_en_i, irq_fall_en_i, irq_clear_i;
  logic [NP-1:0] pad_d_o, pad_oe_o, pad_d_i, in_o, irq_pending_o;
  logic          irq_o;

  mc_pad_gpio_ctrl #(.NumPads(NP), .SyncStages(2), .DebounceCycles(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .out_i         (out_i),
    .oe_i          (oe_i),
    .debounce_en_i (debounce_en_i),
    .irq_rise_en_i (irq_rise_en_i),
    .irq_fall_en_i (irq_fall_en_i),
    .irq_clear_i   (irq_clear_i),
    .pad_d_o       (pad_d_o),
    .pad_oe_o      (pad_oe_o),
    .pad_d_i       (pad_d_i),
    .in_o          (in_o),
    .irq_pending_o (irq_pending_o),
    .irq_o         (irq_o)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [2*NP-1:0] exp_q[$];

  typedef struct {
    logic [NP-1:0] out_v;
    logic [NP-1:0] oe_v;
    logic [NP-1:0] exp_d;
    logic [NP-1:0] exp_oe;
  } vec_t;
  vec_t vecs[6];

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pad_d"},   32'(pad_d_o),       32'h0);
    check({tag, "_pad_oe"},  32'(pad_oe_o),      32'h0);
    check({tag, "_in"},      32'(in_o),          32'h0);
    check({tag, "_pending"}, 32'(irq_pending_o), 32'h0);
    check({tag, "_irq"},     32'(irq_o),         32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2*NP-1:0] exp_v;

    vecs[0] = '{8'h3C, 8'hFF, 8'h3C, 8'hFF};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hAA, 8'hFF, 8'hAA};
    vecs[3] = '{8'h81, 8'h55, 8'h81, 8'h55};
    vecs[4] = '{8'h5A, 8'hF0, 8'h5A, 8'hF0};
    vecs[5] = '{8'hA5, 8'h0F, 8'hA5, 8'h0F};

    rst_ni        = 1'b0;
    out_i         = 8'hA5;
    oe_i          = 8'h0F;
    debounce_en_i = 8'hFF;
    irq_rise_en_i = 8'h00;
    irq_fall_en_i = 8'h00;
    irq_clear_i   = 8'h00;
    pad_d_i       = 8'h00;

    // reset and output path
    tick(2);
    check_all_zero("reset");
    rst_ni = 1'b1;
    check("out_before_edge", 32'(pad_d_o), 32'h0);
    tick(1);
    check("out_d_1cyc",  32'(pad_d_o),  32'hA5);
    check("out_oe_1cyc", 32'(pad_oe_o), 32'h0F);

    for (int i = 0; i < 6; i++) begin
      out_i = vecs[i].out_v;
      oe_i  = vecs[i].oe_v;
      exp_q.push_back({vecs[i].exp_d, vecs[i].exp_oe});
      tick(1);
      exp_v = exp_q.pop_front();
      check($sformatf("vec%0d_d", i),  32'(pad_d_o),  32'(exp_v[2*NP-1:NP]));
      check($sformatf("vec%0d_oe", i), 32'(pad_oe_o), 32'(exp_v[NP-1:0]));
    end
    out_i = 8'h00;
    oe_i  = 8'h00;

    // debounce off on pin 0: in_o at cycle 3, irq at cycle 4
    debounce_en_i = 8'hFE;
    irq_rise_en_i = 8'h01;
    pad_d_i[0]    = 1'b1;
    tick(2);
    check("nodb_in_c2", 32'(in_o[0]), 32'h0);
    tick(1);
    check("nodb_in_c3",  32'(in_o[0]), 32'h1);
    check("nodb_irq_c3", 32'(irq_o),   32'h0);
    tick(1);
    check("nodb_irq_c4",  32'(irq_o),         32'h1);
    check("nodb_pend_c4", 32'(irq_pending_o), 32'h01);
    irq_clear_i = 8'h01;
    tick(1);
    irq_clear_i = 8'h00;
    check("nodb_clear", 32'(irq_pending_o), 32'h00);
    check("nodb_irq_clr", 32'(irq_o), 32'h0);

    // debounce on pin 1: 3-cycle glitch rejected, 4+ cycle level accepted at cycle 6
    irq_rise_en_i = 8'h02;
    pad_d_i[1]    = 1'b1;
    tick(3);
    pad_d_i[1]    = 1'b0;
    tick(8);
    check("db_glitch_in",   32'(in_o[1]),       32'h0);
    check("db_glitch_pend", 32'(irq_pending_o), 32'h00);
    pad_d_i[1] = 1'b1;
    tick(5);
    check("db_in_c5", 32'(in_o[1]), 32'h0);
    tick(1);
    check("db_in_c6",   32'(in_o[1]),          32'h1);
    check("db_pend_c6", 32'(irq_pending_o[1]), 32'h0);
    tick(1);
    check("db_pend_c7", 32'(irq_pending_o), 32'h02);
    irq_clear_i = 8'h02;
    tick(1);
    irq_clear_i = 8'h00;
    check("db_clear", 32'(irq_pending_o), 32'h00);

    // pin 2: clear in the same cycle as a new fall event -> set wins
    debounce_en_i = 8'hFA;
    irq_rise_en_i = 8'h04;
    irq_fall_en_i = 8'h04;
    pad_d_i[2]    = 1'b1;
    tick(4);
    check("prio_rise_pend", 32'(irq_pending_o), 32'h04);
    pad_d_i[2] = 1'b0;
    tick(3);
    check("prio_in_low",  32'(in_o[2]),          32'h0);
    check("prio_pend_c7", 32'(irq_pending_o[2]), 32'h1);
    irq_clear_i = 8'h04;
    tick(1);
    check("prio_set_wins", 32'(irq_pending_o[2]), 32'h1);
    tick(1);
    irq_clear_i = 8'h00;
    check("prio_clear_alone", 32'(irq_pending_o[2]), 32'h0);

    // pin 3: square wave, only falling edges raise pending
    debounce_en_i = 8'hF2;
    irq_rise_en_i = 8'h00;
    irq_fall_en_i = 8'h08;
    for (int k = 0; k < 3; k++) begin
      pad_d_i[3] = 1'b1;
      tick(5);
      check($sformatf("sq%0d_in_hi", k),   32'(in_o[3]),          32'h1);
      check($sformatf("sq%0d_no_rise", k), 32'(irq_pending_o[3]), 32'h0);
      pad_d_i[3] = 1'b0;
      tick(5);
      check($sformatf("sq%0d_in_lo", k), 32'(in_o[3]),          32'h0);
      check($sformatf("sq%0d_fall", k),  32'(irq_pending_o[3]), 32'h1);
      check($sformatf("sq%0d_irq", k),   32'(irq_o),            32'h1);
      irq_clear_i = 8'h08;
      tick(1);
      irq_clear_i = 8'h00;
      check($sformatf("sq%0d_clr", k), 32'(irq_pending_o[3]), 32'h0);
    end

    // reset mid-debounce with pad 4 high, then re-acquisition as a rise
    debounce_en_i = 8'hFF;
    irq_rise_en_i = 8'h10;
    irq_fall_en_i = 8'h00;
    out_i         = 8'hFF;
    oe_i          = 8'hFF;
    pad_d_i       = 8'h10;
    tick(3);
    check("pre_rst_pad_d", 32'(pad_d_o), 32'hFF);
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick(2);
    check_all_zero("held_rst");
    rst_ni = 1'b1;
    tick(1);
    check("post_rst_pad_d", 32'(pad_d_o), 32'hFF);
    tick(4);
    check("reacq_in_c5", 32'(in_o), 32'h00);
    tick(1);
    check("reacq_in_c6",   32'(in_o),          32'h10);
    check("reacq_pend_c6", 32'(irq_pending_o), 32'h00);
    tick(1);
    check("reacq_pend_c7", 32'(irq_pending_o), 32'h10);
    check("reacq_irq_c7",  32'(irq_o),         32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
